// File: rtl/reg_bank_sb.sv
// Parametrised CPU register bank: two async read ports, one write port, PC/SR update paths
// and a pending-write scoreboard. Optional read-during-write forwarding under `BYPASS_EN.
module reg_bank_sb #(
   parameter int unsigned          DATA_W       = 16,
   parameter int unsigned          NUM_REGS     = 16,
   parameter int unsigned          IDX_W        = 4,
   parameter int unsigned          PC_IDX       = 0,
   parameter int unsigned          SR_IDX       = 2,
   parameter int unsigned          PC_STEP      = 2,
   parameter logic [DATA_W-1:0]    RESET_VECTOR = '0,
   parameter int unsigned          SR_FLAG_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IDX_W-1:0]     src_reg,
   input  logic [IDX_W-1:0]     dst_reg,
   output logic [DATA_W-1:0]    a,
   output logic [DATA_W-1:0]    b,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_reg,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 pc_inc,
   input  logic                 pc_load,
   input  logic [DATA_W-1:0]    pc_data_in,
   output logic [DATA_W-1:0]    pc_data_out,
   input  logic                 sr_we,
   input  logic [SR_FLAG_W-1:0] sr_flags,
   output logic [DATA_W-1:0]    sr_data_out,
   input  logic                 busy_set,
   input  logic [IDX_W-1:0]     busy_idx,
   input  logic                 rd_chk,
   output logic                 hazard,
   output logic [NUM_REGS-1:0]  busy_vec
);

   localparam logic [IDX_W-1:0] PC_SEL = IDX_W'(PC_IDX);
   localparam logic [IDX_W-1:0] SR_SEL = IDX_W'(SR_IDX);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] busy_eff;
   logic [DATA_W-1:0]   pc_nxt;
   logic                wr_pc;
   logic                wr_sr;

   assign wr_pc = wr_en && (wr_reg == PC_SEL);
   assign wr_sr = wr_en && (wr_reg == SR_SEL);

   // Next state: general write, then PC and SR dedicated paths, then scoreboard
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      pc_nxt = regs_q[PC_IDX];
      if (wr_en) regs_d[wr_reg] = wr_data;
      if (wr_pc)        pc_nxt = wr_data;
      else if (pc_load) pc_nxt = pc_data_in;
      else if (pc_inc)  pc_nxt = regs_q[PC_IDX] + DATA_W'(PC_STEP);
      regs_d[PC_IDX] = {pc_nxt[DATA_W-1:1], 1'b0};
      if (!wr_sr && sr_we) regs_d[SR_IDX][SR_FLAG_W-1:0] = sr_flags;
      if (wr_en) busy_d[wr_reg] = 1'b0;
      // Set beats clear on the same index; the PC is never pending
      if (busy_set && (busy_idx != PC_SEL)) busy_d[busy_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            regs_q[i] <= (i == PC_IDX) ? RESET_VECTOR : '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports and hazard qualification
   always_comb begin
      a        = regs_q[src_reg];
      b        = regs_q[dst_reg];
      busy_eff = busy_q;
`ifdef BYPASS_EN
      if (wr_en) begin
         busy_eff[wr_reg] = 1'b0;
         if (wr_reg == src_reg) a = wr_pc ? {wr_data[DATA_W-1:1], 1'b0} : wr_data;
         if (wr_reg == dst_reg) b = wr_pc ? {wr_data[DATA_W-1:1], 1'b0} : wr_data;
      end
`endif
      hazard = rd_chk & (busy_eff[src_reg] | busy_eff[dst_reg]);
   end

   assign pc_data_out = regs_q[PC_IDX];
   assign sr_data_out = regs_q[SR_IDX];
   assign busy_vec    = busy_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: stimulus pushes expected outputs, a negedge monitor compares.
module tb_reg_bank_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  src_reg, dst_reg, wr_reg, busy_idx;
   logic [15:0] a, b, wr_data, pc_data_in, pc_data_out, sr_data_out, busy_vec;
   logic        wr_en, pc_inc, pc_load, sr_we, busy_set, rd_chk, hazard;
   logic [3:0]  sr_flags;

   logic [4:0]  src32, dst32, wr_reg32, busy_idx32;
   logic [31:0] a32, b32, wr_data32, pc_in32, pc_out32, sr_out32, busy_vec32;
   logic        wr_en32, pc_inc32, pc_load32, hazard32;

   always #5 clk = ~clk;

   reg_bank_sb #(.RESET_VECTOR(16'h0100)) dut (
      .clk(clk), .rst_n(rst_n), .src_reg(src_reg), .dst_reg(dst_reg), .a(a), .b(b),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pc_inc(pc_inc), .pc_load(pc_load),
      .pc_data_in(pc_data_in), .pc_data_out(pc_data_out), .sr_we(sr_we), .sr_flags(sr_flags),
      .sr_data_out(sr_data_out), .busy_set(busy_set), .busy_idx(busy_idx), .rd_chk(rd_chk),
      .hazard(hazard), .busy_vec(busy_vec));

   reg_bank_sb #(.DATA_W(32), .NUM_REGS(32), .IDX_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .src_reg(src32), .dst_reg(dst32), .a(a32), .b(b32),
      .wr_en(wr_en32), .wr_reg(wr_reg32), .wr_data(wr_data32), .pc_inc(pc_inc32),
      .pc_load(pc_load32), .pc_data_in(pc_in32), .pc_data_out(pc_out32), .sr_we(1'b0),
      .sr_flags(4'h0), .sr_data_out(sr_out32), .busy_set(1'b0), .busy_idx(busy_idx32),
      .rd_chk(1'b0), .hazard(hazard32), .busy_vec(busy_vec32));

   typedef struct {
      logic [15:0] a, b, pc, sr, busy;
      logic        hz;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_regs [16];
   logic [15:0] m_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are stable mid-cycle, so compare at the falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("a", 32'(a), 32'(e.a));
         chk("b", 32'(b), 32'(e.b));
         chk("pc", 32'(pc_data_out), 32'(e.pc));
         chk("sr", 32'(sr_data_out), 32'(e.sr));
         chk("busy_vec", 32'(busy_vec), 32'(e.busy));
         chk("hazard", 32'(hazard), 32'(e.hz));
      end
   end

   function automatic logic [15:0] rd_model(input logic [3:0] idx);
      logic [15:0] v;
      v = m_regs[idx];
`ifdef BYPASS_EN
      if (wr_en && wr_reg == idx) v = (idx == 4'd0) ? (wr_data & 16'hFFFE) : wr_data;
`endif
      return v;
   endfunction

   function automatic exp_t predict();
      exp_t        e;
      logic [15:0] bz;
      bz = m_busy;
`ifdef BYPASS_EN
      if (wr_en) bz[wr_reg] = 1'b0;
`endif
      e.a    = rd_model(src_reg);
      e.b    = rd_model(dst_reg);
      e.pc   = m_regs[0];
      e.sr   = m_regs[2];
      e.busy = m_busy;
      e.hz   = rd_chk && (bz[src_reg] || bz[dst_reg]);
      return e;
   endfunction

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = 16'h0000;
      m_regs[0] = 16'h0100;
      m_busy    = 16'h0000;
   endtask

   // Architectural effect of one clock edge, stated from the register-bank rules
   task automatic model_edge();
      logic [15:0] nr [16];
      logic [15:0] nb;
      logic [15:0] pc;
      nr = m_regs;
      nb = m_busy;
      if (wr_en) nr[wr_reg] = wr_data;
      if (wr_en && wr_reg == 4'd0) pc = wr_data;
      else if (pc_load)            pc = pc_data_in;
      else if (pc_inc)             pc = m_regs[0] + 16'd2;
      else                         pc = m_regs[0];
      nr[0] = pc & 16'hFFFE;
      if (sr_we && !(wr_en && wr_reg == 4'd2)) nr[2] = (m_regs[2] & 16'hFFF0) | {12'h000, sr_flags};
      if (wr_en) nb[wr_reg] = 1'b0;
      if (busy_set && busy_idx != 4'd0) nb[busy_idx] = 1'b1;
      m_regs = nr;
      m_busy = nb;
   endtask

   task automatic idle();
      {wr_en, pc_inc, pc_load, sr_we, busy_set, rd_chk} = '0;
      {src_reg, dst_reg, wr_reg, busy_idx, sr_flags} = '0;
      wr_data = '0;
      pc_data_in = '0;
   endtask

   // Called just after a rising edge with inputs driven for the coming cycle
   task automatic step();
      q.push_back(predict());
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Asynchronous reset asserted between edges; a write on the held edge must be dropped
   task automatic async_reset();
      idle();
      #2 rst_n = 1'b0;
      model_reset();
      q.push_back(predict());
      wr_en = 1'b1; wr_reg = 4'd9; wr_data = 16'h5A5A;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      {src32, dst32, wr_reg32, busy_idx32, wr_en32, pc_inc32, pc_load32} = '0;
      wr_data32 = '0; pc_in32 = '0;
      model_reset();
      @(posedge clk); #1;
      async_reset();

      src_reg = 4'd0; dst_reg = 4'd3; step();
      wr_en = 1'b1; wr_reg = 4'd5; wr_data = 16'hBEEF; src_reg = 4'd5; dst_reg = 4'd5; step();
      idle(); src_reg = 4'd5; dst_reg = 4'd5; step();

      idle(); pc_load = 1'b1; pc_data_in = 16'hFFFE; step();
      idle(); pc_inc = 1'b1; step();
      idle(); pc_inc = 1'b1; pc_load = 1'b1; pc_data_in = 16'h1235; step();
      idle(); pc_inc = 1'b1; pc_load = 1'b1; pc_data_in = 16'h2222;
      wr_en = 1'b1; wr_reg = 4'd0; wr_data = 16'h4000; step();

      idle(); wr_en = 1'b1; wr_reg = 4'd2; wr_data = 16'hFF00; step();
      idle(); sr_we = 1'b1; sr_flags = 4'hA; step();
      idle(); sr_we = 1'b1; sr_flags = 4'h6; wr_en = 1'b1; wr_reg = 4'd2; wr_data = 16'h0001; step();

      idle(); busy_set = 1'b1; busy_idx = 4'd7; step();
      idle(); rd_chk = 1'b1; src_reg = 4'd7; dst_reg = 4'd1; step();
      idle(); busy_set = 1'b1; busy_idx = 4'd7; wr_en = 1'b1; wr_reg = 4'd7; wr_data = 16'h7777; step();
      idle(); rd_chk = 1'b1; src_reg = 4'd1; dst_reg = 4'd7; busy_set = 1'b1; busy_idx = 4'd0; step();
      idle(); rd_chk = 1'b1; src_reg = 4'd0; dst_reg = 4'd7; wr_en = 1'b1; wr_reg = 4'd7; step();
      idle(); rd_chk = 1'b1; src_reg = 4'd7; dst_reg = 4'd0; step();

      async_reset();

      for (int n = 0; n < 500; n++) begin
         src_reg    = 4'($urandom_range(0, 15));
         dst_reg    = 4'($urandom_range(0, 15));
         wr_en      = ($urandom_range(0, 9) < 4);
         wr_reg     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
         wr_data    = 16'($urandom);
         pc_inc     = ($urandom_range(0, 2) == 0);
         pc_load    = ($urandom_range(0, 5) == 0);
         pc_data_in = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         sr_we      = ($urandom_range(0, 3) == 0);
         sr_flags   = 4'($urandom);
         busy_set   = ($urandom_range(0, 9) < 3);
         busy_idx   = 4'($urandom_range(0, 15));
         rd_chk     = ($urandom_range(0, 1) == 1);
         step();
      end
      idle();
      @(negedge clk); #1;
      chk("queue_drained", 32'(q.size()), 32'd0);

      // Wide configuration: top register and full-width PC wrap
      @(posedge clk); #1;
      wr_en32 = 1'b1; wr_reg32 = 5'd31; wr_data32 = 32'hDEADBEEF; src32 = 5'd31; dst32 = 5'd31;
      @(posedge clk); #1;
      wr_en32 = 1'b0;
      chk("w32_a", a32, 32'hDEADBEEF);
      chk("w32_b", b32, 32'hDEADBEEF);
      pc_load32 = 1'b1; pc_in32 = 32'hFFFFFFFE;
      @(posedge clk); #1;
      pc_load32 = 1'b0;
      chk("w32_pc_load", pc_out32, 32'hFFFFFFFE);
      pc_inc32 = 1'b1;
      @(posedge clk); #1;
      pc_inc32 = 1'b0;
      chk("w32_pc_wrap", pc_out32, 32'h00000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
Parametrised successor to the 16x16 CPU register bank. Provides NUM_REGS x DATA_W registers, two asynchronous read ports and one synchronous write port. PC and status register live at fixed indices and have dedicated update paths: PC increment/load and SR flag update. A per-register pending-write scoreboard raises a hazard flag for the control unit. Sits between the control unit/ALU writeback and the ALU operand inputs.

Parameters:
DATA_W, 16, register width in bits (>=8)
NUM_REGS, 16, register count; power of 2, >=4
IDX_W, 4, index width; must equal log2(NUM_REGS)
PC_IDX, 0, index of program counter
SR_IDX, 2, index of status register
PC_STEP, 2, PC increment amount
RESET_VECTOR, 0, PC value after reset (bit0 must be 0)
SR_FLAG_W, 4, low SR bits written by the flag path

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
src_reg  in  IDX_W  read port A index
dst_reg  in  IDX_W  read port B index
a  out  DATA_W  regs[src_reg]
b  out  DATA_W  regs[dst_reg]
wr_en  in  1  general write strobe
wr_reg  in  IDX_W  write index
wr_data  in  DATA_W  write data
pc_inc  in  1  PC += PC_STEP
pc_load  in  1  PC <= pc_data_in
pc_data_in  in  DATA_W  PC load value
pc_data_out  out  DATA_W  current PC
sr_we  in  1  flag update strobe
sr_flags  in  SR_FLAG_W  new flag values for SR[SR_FLAG_W-1:0]
sr_data_out  out  DATA_W  current SR
busy_set  in  1  mark busy_idx pending (instruction issued)
busy_idx  in  IDX_W  register to mark pending
rd_chk  in  1  qualify hazard check this cycle
hazard  out  1  rd_chk & (busy[src_reg] | busy[dst_reg])
busy_vec  out  NUM_REGS  scoreboard state

Behaviour:
- Reset (rst_n=0, async): all regs 0 except PC=RESET_VECTOR; busy_vec=0. Outputs therefore read: a/b as indexed (0, or RESET_VECTOR at PC_IDX), pc_data_out=RESET_VECTOR, sr_data_out=0, hazard=0. Reset asserted mid-operation discards any same-edge write.
- Reads combinational, zero latency. Without bypass, a write becomes visible the cycle after its clock edge.
- General write: on posedge with wr_en, regs[wr_reg]<=wr_data.
- PC path priority, highest first: wr_en & wr_reg==PC_IDX > pc_load > pc_inc. Increment wraps mod 2^DATA_W (0xFFFE+2 -> 0x0000 at DATA_W=16). PC bit0 is forced 0 on every PC update, whichever path.
- SR path: wr_en & wr_reg==SR_IDX beats sr_we. With sr_we alone, SR[SR_FLAG_W-1:0]<=sr_flags; upper SR bits are unchanged.
- Scoreboard: busy_set sets busy[busy_idx]; wr_en clears busy[wr_reg]. When both hit the same index on the same edge, set wins. busy_set on PC_IDX is ignored, so PC is never pending. hazard is combinational.
- Out-of-range indices are impossible: power-of-2 depth fully decodes IDX_W.

Optional Feature:
BYPASS_EN. When defined, read-during-write forwarding is added: if wr_en & wr_reg==src_reg, a=wr_data in the same cycle; likewise for b. hazard also ignores busy for the index being written this cycle. PC and SR reads are forwarded only from the general write port, never from the pc_inc, pc_load or sr_we paths. Without BYPASS_EN: a/b show the old value until the edge, and hazard uses the registered busy_vec only.

Test Plan:
- Reset: rst_n low with RESET_VECTOR=0x0100 -> pc_data_out=0x0100, busy_vec=0, all other regs read 0. Pulse rst_n asynchronously between edges -> state clears immediately.
- Write/read: wr_en, wr_reg=5, wr_data=0xBEEF; then src_reg=5, dst_reg=5 -> a=b=0xBEEF next cycle. Same cycle: old value, or 0xBEEF with BYPASS_EN.
- PC priority: PC=0xFFFE, pc_inc -> 0x0000. pc_inc+pc_load(0x1235) -> 0x1234. All three with wr_data=0x4000 to PC_IDX -> 0x4000.
- SR: SR=0xFF00, sr_we, sr_flags=0xA -> 0xFF0A. sr_we plus wr_en to SR_IDX with 0x0001 -> 0x0001.
- Scoreboard: busy_set idx 7; then rd_chk, src_reg=7 -> hazard=1. wr_en wr_reg=7 with busy_set idx 7 on the same edge -> busy stays 1. busy_set idx PC_IDX -> busy_vec[PC_IDX]=0.
- Parametric: DATA_W=32, NUM_REGS=32, IDX_W=5 -> write/read reg 31 with 0xDEADBEEF passes; PC wraps 0xFFFFFFFE -> 0.
